// File: rtl/dmem_mmio_if.sv
// ============================================================================
// Module   : dmem_mmio_if
// Brief    : Core-side data bus (address, store data, strobe, load data).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wmem;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output wmem, input rdata);
  modport slave  (input addr, input wdata, input wmem, output rdata);
endinterface

`default_nettype wire

// File: rtl/dmem_mmio.sv
// ============================================================================
// Module   : dmem_mmio
// Brief    : Data RAM plus GPIO, free-running timer and FIFO-backed UART TX.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_mmio #(
  parameter int RAM_AW       = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic        i_clk,
  input  wire logic        i_resetn,
  dmem_mmio_if.slave       bus,
  output logic [31:0]      o_gpio,
  output logic             o_uart_tx
);

  localparam int c_ram_depth = 1 << RAM_AW;
  localparam int c_ptr_w     = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w     = $clog2(FIFO_DEPTH + 1);
  localparam int c_baud_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0]  c_fifo_full = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [31:0]        r_ram [c_ram_depth];
  logic [31:0]        r_gpio;
  logic [31:0]        r_timer;
  logic [7:0]         r_fifo [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  state_t              r_state, w_state_nx;
  logic [c_baud_w-1:0] r_baud, w_baud_nx;
  logic [2:0]          r_bit, w_bit_nx;
  logic [7:0]          r_shift, w_shift_nx;
  logic                r_tx, w_tx_nx;
  logic                w_pop, w_push;

  // Word-aligned accesses: the byte offset carries no meaning here.
  logic w_unused;
  assign w_unused = &{1'b0, bus.addr[1:0]};

  logic              w_io, w_reg_hit;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_gpio, w_wr_timer, w_wr_tx;
  logic              w_full, w_empty, w_busy;

  assign w_io       = bus.addr[31];
  assign w_reg_hit  = w_io && (bus.addr[30:4] == 27'd0);
  assign w_ram_idx  = bus.addr[RAM_AW+1:2];
  assign w_wr_gpio  = bus.wmem && w_reg_hit && (bus.addr[3:2] == 2'd0);
  assign w_wr_timer = bus.wmem && w_reg_hit && (bus.addr[3:2] == 2'd1);
  assign w_wr_tx    = bus.wmem && w_reg_hit && (bus.addr[3:2] == 2'd2);
  assign w_full     = (r_count == c_fifo_full);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push     = w_wr_tx && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (bus.wmem && !w_io) r_ram[w_ram_idx] <= bus.wdata;
    if (w_push)            r_fifo[r_wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_gpio   <= '0;
      r_timer  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_gpio) r_gpio <= bus.wdata;
      r_timer <= w_wr_timer ? bus.wdata : r_timer + 32'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

  // tx is registered, so each branch sets the level for the state being entered.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud + c_baud_w'(1);
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        w_tx_nx   = 1'b1;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_fifo[r_rd_ptr];
          w_bit_nx   = '0;
          w_tx_nx    = 1'b0;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (r_baud == c_baud_last) begin
          w_baud_nx  = '0;
          w_tx_nx    = r_shift[0];
          w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (r_baud == c_baud_last) begin
          w_baud_nx = '0;
          if (r_bit == 3'd7) begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_STOP;
          end else begin
            w_shift_nx = {1'b0, r_shift[7:1]};
            w_bit_nx   = r_bit + 3'd1;
            w_tx_nx    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (r_baud == c_baud_last) begin
          w_baud_nx  = '0;
          w_tx_nx    = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  logic [31:0] w_cnt_ext;
  logic [2:0]  w_cnt_sat;
  logic [31:0] w_rdata;

  always_comb begin
    w_cnt_ext = 32'(r_count);
    w_cnt_sat = (w_cnt_ext > 32'd7) ? 3'd7 : w_cnt_ext[2:0];
    w_rdata   = 32'd0;
    if (!w_io) begin
      w_rdata = r_ram[w_ram_idx];
    end else if (w_reg_hit) begin
      case (bus.addr[3:2])
        2'd0:    w_rdata = r_gpio;
        2'd1:    w_rdata = r_timer;
        2'd3:    w_rdata = {27'd0, w_cnt_sat, w_busy, w_full};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign o_gpio    = r_gpio;
  assign o_uart_tx = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio.sv
// ============================================================================
// Module   : tb_dmem_mmio
// Brief    : Scoreboard bench for dmem_mmio against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam logic [31:0] A_GPIO = 32'h8000_0000;
  localparam logic [31:0] A_TMR  = 32'h8000_0004;
  localparam logic [31:0] A_TXD  = 32'h8000_0008;
  localparam logic [31:0] A_STAT = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gpio;
  logic        tx;

  dmem_mmio_if bus ();

  dmem_mmio #(.RAM_AW(AW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .i_clk     (clk),
    .i_resetn  (rst_n),
    .bus       (bus),
    .o_gpio    (gpio),
    .o_uart_tx (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 rdata, 1 uart tx, 2 gpio
    logic [31:0] exp;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: RAM by word index, FIFO as a byte queue, frame as position.
  logic [31:0] m_mem [int];
  logic [31:0] m_gpio  = '0;
  logic [31:0] m_timer = '0;
  logic [7:0]  m_fifo[$];
  bit          m_active = 1'b0;
  int          m_pos = 0;
  logic [7:0]  m_byte = '0;

  function automatic logic m_tx_level();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    int cnt;
    known = 1'b1;
    if (!a[31]) begin
      if (m_mem.exists(int'(a[AW+1:2]))) return m_mem[int'(a[AW+1:2])];
      known = 1'b0;
      return '0;
    end
    if (a[30:4] != 27'd0) return '0;
    case (a[3:2])
      2'd0:    return m_gpio;
      2'd1:    return m_timer;
      2'd2:    return '0;
      default: begin
        cnt = (m_fifo.size() > 7) ? 7 : m_fifo.size();
        return {27'd0, 3'(cnt), m_active, (m_fifo.size() == DEPTH)};
      end
    endcase
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
    exp_t e;
    bit   known;
    bit   pop;
    int   pre_size;
    bit   hit;
    @(negedge clk);
    cyc++;
    bus.addr  = a;
    bus.wdata = d;
    bus.wmem  = w;
    e.cyc = cyc; e.kind = 0; e.addr = a; e.exp = m_read(a, known);
    if (known) sb_q.push_back(e);
    hit      = a[31] && (a[30:4] == 27'd0);
    pre_size = m_fifo.size();
    pop      = !m_active && (pre_size > 0);
    if (m_active) begin
      m_pos++;
      if (m_pos == 10 * CPB) m_active = 1'b0;
    end else if (pop) begin
      m_byte   = m_fifo.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (w && hit && a[3:2] == 2'd2 && (pre_size < DEPTH || pop)) m_fifo.push_back(d[7:0]);
    m_timer = (w && hit && a[3:2] == 2'd1) ? d : m_timer + 32'd1;
    if (w && hit && a[3:2] == 2'd0) m_gpio = d;
    if (w && !a[31]) m_mem[int'(a[AW+1:2])] = d;
    e.cyc = cyc + 1; e.kind = 1; e.addr = a; e.exp = {31'd0, m_tx_level()};
    sb_q.push_back(e);
    e.kind = 2; e.exp = m_gpio;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares every DUT output the scoreboard has an expectation for.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e   = sb_q.pop_front();
        act = (e.kind == 0) ? bus.rdata : (e.kind == 1) ? {31'd0, tx} : gpio;
        checks++;
        if (act !== e.exp || e.cyc != cyc) begin
          errors++;
          $display("FAIL %s cyc %0d addr %h got %h expected %h (due cyc %0d)",
                   (e.kind == 0) ? "rdata" : (e.kind == 1) ? "uart_tx" : "gpio",
                   cyc, e.addr, act, e.exp, e.cyc);
        end
      end
    end
  end

  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_gpio", gpio, 32'd0);
    bus.wmem = 1'b0;
    m_gpio = '0; m_timer = '0; m_fifo.delete(); m_active = 1'b0; m_pos = 0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    bus.addr = '0; bus.wdata = '0; bus.wmem = 1'b0;
    #12;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_gpio", gpio, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // RAM store/load and byte-offset aliasing
    step(32'h10, 32'hDEAD_BEEF, 1'b1);
    step(32'h14, 32'h1234_5678, 1'b1);
    step(32'h10, 32'h0, 1'b0);
    step(32'h14, 32'h0, 1'b0);
    step(32'h11, 32'h0, 1'b0);
    step(32'h1010, 32'h0, 1'b0);
    // GPIO and unmapped IO
    step(A_GPIO, 32'hA5, 1'b1);
    step(A_GPIO, 32'h0, 1'b0);
    step(32'h8000_0010, 32'h0, 1'b1);
    step(32'h8000_0010, 32'h0, 1'b0);
    // Timer load and wrap
    step(A_TMR, 32'hFFFF_FFFE, 1'b1);
    repeat (3) step(A_TMR, 32'h0, 1'b0);
    // Single frame
    step(A_TXD, 32'hA5, 1'b1);
    repeat (45) step(A_STAT, 32'h0, 1'b0);
    // Back-to-back pushes, sixth one dropped
    for (int i = 1; i <= 6; i++) step(A_TXD, 32'(i), 1'b1);
    repeat (215) step(A_STAT, 32'h0, 1'b0);
    // Reset mid-DATA with two bytes queued
    step(A_GPIO, 32'h5A, 1'b1);
    step(A_TXD, 32'h00, 1'b1);
    step(A_TXD, 32'h11, 1'b1);
    step(A_TXD, 32'h22, 1'b1);
    repeat (9) step(A_STAT, 32'h0, 1'b0);
    reset_mid();
    repeat (50) step(A_STAT, 32'h0, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        5:       a = A_GPIO;
        6:       a = A_TMR;
        7:       a = A_TXD;
        8:       a = A_STAT;
        9: begin
          a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF0);
          if (a[30:4] == 27'd0) a[4] = 1'b1;
        end
        default: a = {20'd0, 12'($urandom)};
      endcase
      step(a, $urandom, 1'($urandom_range(0, 1)));
    end
    repeat (60) step(A_STAT, 32'h0, 1'b0);

    @(negedge clk);
    cyc++;
    #4;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
